// File: rtl/vq_pkg.sv
// vq_pkg: constants and FSM state encoding shared by the VQ centroid-update
// controller and its serial divider.
package vq_pkg;

   localparam int NUM_CW   = 16;   // codewords
   localparam int NUM_COEF = 13;   // coefficients per codeword
   localparam int ACC_W    = 24;   // accumulator width (signed)
   localparam int CNT_W    = 9;    // frame-count width (unsigned)
   localparam int DATA_W   = 14;   // codebook word width (signed)
   localparam int CB_DEPTH = NUM_CW * NUM_COEF;  // 208 entries
   localparam int ADDR_W   = 8;

   localparam int CENT_MAX = 8191;
   localparam int CENT_MIN = -8192;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_DIV,
      ST_WRITE,
      ST_NEXT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/vq_div_serial.sv
// vq_div_serial: unsigned restoring divider, one quotient bit per cycle.
// The start cycle performs the first step, so the quotient is complete after
// ACC_W clock edges and valid rises in the cycle after the last step. valid
// holds until the next start.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       load dividend/divisor and begin (one-cycle pulse)
//   dividend    unsigned magnitude, ACC_W bits
//   divisor     unsigned, CNT_W bits, must be nonzero and stable while running
//   quotient    ACC_W-bit unsigned result
//   valid       quotient ready
module vq_div_serial
   import vq_pkg::*;
#(
   parameter int DVD_W = vq_pkg::ACC_W,
   parameter int DVS_W = vq_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVD_W-1:0] quotient,
   output logic             valid
);

   localparam int SC_W = $clog2(DVD_W + 1);

   logic [DVS_W-1:0] rem, rem_in, rem_nx;
   logic [DVD_W-1:0] quo, quo_in, quo_nx;
   logic [DVS_W:0]   rem_sh;
   logic [SC_W-1:0]  steps;
   logic             ge;

   // One restoring step; on start it operates on the fresh operands.
   always_comb begin
      rem_in = start ? '0 : rem;
      quo_in = start ? dividend : quo;
      rem_sh = {rem_in, quo_in[DVD_W-1]};
      ge     = (rem_sh >= {1'b0, divisor});
      // remainder after subtraction is < divisor, so the low bits suffice
      rem_nx = ge ? (rem_sh[DVS_W-1:0] - divisor) : rem_sh[DVS_W-1:0];
      quo_nx = {quo_in[DVD_W-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem   <= '0;
         quo   <= '0;
         steps <= '0;
         valid <= 1'b0;
      end else if (start) begin
         rem   <= rem_nx;
         quo   <= quo_nx;
         steps <= SC_W'(DVD_W - 1);
         valid <= 1'b0;
      end else if (steps != '0) begin
         rem   <= rem_nx;
         quo   <= quo_nx;
         steps <= steps - SC_W'(1);
         if (steps == SC_W'(1)) valid <= 1'b1;
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/vq_centroid_update_ctrl.sv
// vq_centroid_update_ctrl: walks all NUM_CW x NUM_COEF accumulator entries,
// divides each signed sum by its codeword's frame count (truncating toward
// zero), saturates to 14 bits and writes the centroid into the codebook.
// Codewords with a zero count are skipped and keep their old centroid.
// Optional feature macro: VQ_CENTROID_CHANGE_SUM_EN (reads the old codebook
// and accumulates sum |new-old| per pass into change_sum).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, busy, done pass control / status
//   frames_cnt_flat   per-codeword frame counts, stable while busy
//   acc_rd_addr/data  accumulator read port (1-cycle latency)
//   cb_rd_addr/data   old-codebook read port (1-cycle latency, macro only)
//   cb_wr_addr/data/en codebook write port
//   change_sum        total centroid movement of last pass (macro only)
module vq_centroid_update_ctrl
   import vq_pkg::*;
#(
   parameter int NUM_CW   = vq_pkg::NUM_CW,
   parameter int NUM_COEF = vq_pkg::NUM_COEF,
   parameter int ACC_W    = vq_pkg::ACC_W,
   parameter int CNT_W    = vq_pkg::CNT_W,
   parameter int DATA_W   = vq_pkg::DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic [NUM_CW*CNT_W-1:0] frames_cnt_flat,
   output logic [7:0]              acc_rd_addr,
   input  logic [ACC_W-1:0]        acc_rd_data,
   output logic [7:0]              cb_rd_addr,
   input  logic [DATA_W-1:0]       cb_rd_data,
   output logic [7:0]              cb_wr_addr,
   output logic [DATA_W-1:0]       cb_wr_data,
   output logic                    cb_wr_en,
   output logic [21:0]             change_sum
);

   state_t           state, state_nx;
   logic [3:0]       k, c;
   logic [7:0]       addr;
   logic             neg_q;
   logic [CNT_W-1:0] cnt_k;
   logic             last;
   logic             div_start, div_valid;
   logic [ACC_W-1:0] div_mag, div_quo;
   logic [DATA_W-1:0] cent;

   assign cnt_k = frames_cnt_flat[k*CNT_W +: CNT_W];
   assign last  = (k == 4'(NUM_CW - 1)) && (c == 4'(NUM_COEF - 1));

   // magnitude of 24'h800000 is 2^23, still representable unsigned
   assign div_mag = acc_rd_data[ACC_W-1] ? (~acc_rd_data + ACC_W'(1)) : acc_rd_data;

   vq_div_serial #(.DVD_W(ACC_W), .DVS_W(CNT_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (div_mag),
      .divisor  (cnt_k),
      .quotient (div_quo),
      .valid    (div_valid)
   );

   // Reapply sign and saturate the unsigned quotient.
   always_comb begin
      cent = '0;
      if (!neg_q) begin
         if (div_quo > ACC_W'(CENT_MAX)) cent = DATA_W'(CENT_MAX);
         else                            cent = div_quo[DATA_W-1:0];
      end else begin
         if (div_quo > ACC_W'(-CENT_MIN)) cent = DATA_W'(CENT_MIN);
         else                             cent = ~div_quo[DATA_W-1:0] + DATA_W'(1);
      end
   end

   always_comb begin
      state_nx  = state;
      div_start = 1'b0;
      case (state)
         ST_IDLE:    if (start) state_nx = ST_RD_ADDR;
         ST_RD_ADDR: state_nx = (cnt_k == '0) ? ST_NEXT : ST_RD_DATA;
         ST_RD_DATA: begin
            div_start = 1'b1;
            state_nx  = ST_DIV;
         end
         ST_DIV:     if (div_valid) state_nx = ST_WRITE;
         // WRITE also advances the entry so a divided entry costs 27 cycles
         ST_WRITE,
         ST_NEXT:    state_nx = last ? ST_DONE : ST_RD_ADDR;
         ST_DONE:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         k     <= '0;
         c     <= '0;
         addr  <= '0;
         neg_q <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: if (start) begin
               k    <= '0;
               c    <= '0;
               addr <= '0;
            end
            ST_RD_DATA: neg_q <= acc_rd_data[ACC_W-1];
            ST_WRITE,
            ST_NEXT: if (!last) begin
               addr <= addr + 8'd1;
               if (c == 4'(NUM_COEF - 1)) begin
                  c <= '0;
                  k <= k + 4'd1;
               end else begin
                  c <= c + 4'd1;
               end
            end
            ST_DONE: addr <= '0;
            default: ;
         endcase
      end
   end

   assign busy        = (state != ST_IDLE) && (state != ST_DONE);
   assign done        = (state == ST_DONE);
   assign acc_rd_addr = addr;
   assign cb_wr_en    = (state == ST_WRITE);
   assign cb_wr_addr  = cb_wr_en ? addr : 8'd0;
   assign cb_wr_data  = cb_wr_en ? cent : '0;

`ifdef VQ_CENTROID_CHANGE_SUM_EN
   logic [DATA_W-1:0] old_q;
   logic [DATA_W:0]   diff;
   logic [DATA_W:0]   adiff;
   logic [21:0]       chg_acc, chg_q;

   assign diff  = {cent[DATA_W-1], cent} - {old_q[DATA_W-1], old_q};
   assign adiff = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         old_q   <= '0;
         chg_acc <= '0;
         chg_q   <= '0;
      end else begin
         case (state)
            ST_IDLE:    if (start) chg_acc <= '0;
            ST_RD_DATA: old_q <= cb_rd_data;
            ST_WRITE:   chg_acc <= chg_acc + 22'(adiff);
            ST_DONE:    chg_q <= chg_acc;
            default: ;
         endcase
      end
   end

   assign cb_rd_addr = addr;
   assign change_sum = chg_q;
`else
   logic unused_cb_rd;
   assign unused_cb_rd = ^cb_rd_data;
   assign cb_rd_addr   = 8'd0;
   assign change_sum   = 22'd0;
`endif

endmodule

// File: tb/tb_vq_centroid_update_ctrl.sv
module tb_vq_centroid_update_ctrl;
   import vq_pkg::*;

   localparam int NCW = 16, NCO = 13, AW = 24, CW = 9, DW = 14, DEPTH = 208;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, cb_wr_en;
   logic [NCW*CW-1:0] frames_cnt_flat = '0;
   logic [7:0]        acc_rd_addr, cb_rd_addr, cb_wr_addr;
   logic [AW-1:0]     acc_rd_data = '0;
   logic [DW-1:0]     cb_rd_data = '0, cb_wr_data;
   logic [21:0]       change_sum;

   vq_centroid_update_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .frames_cnt_flat(frames_cnt_flat),
      .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
      .cb_rd_addr(cb_rd_addr), .cb_rd_data(cb_rd_data),
      .cb_wr_addr(cb_wr_addr), .cb_wr_data(cb_wr_data), .cb_wr_en(cb_wr_en),
      .change_sum(change_sum)
   );

   always #5 clk = ~clk;

   // memory models
   logic signed [AW-1:0] acc_mem [DEPTH];
   logic signed [DW-1:0] old_mem [DEPTH];
   int cnt_tab [NCW];

   always @(posedge clk) begin
      acc_rd_data <= (acc_rd_addr < DEPTH) ? acc_mem[acc_rd_addr] : '0;
      cb_rd_data  <= (cb_rd_addr  < DEPTH) ? old_mem[cb_rd_addr]  : '0;
   end

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  n_checks = 0, n_fail = 0;
   int  exp_mem [DEPTH];
   bit  exp_wr  [DEPTH];
   int  got_mem [DEPTH];
   bit  got_wr  [DEPTH];
   int  wr_cnt;
   int  exp_cycles, exp_writes;
   longint exp_chg;
   int  mon_a;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Reference: integer division truncates toward zero, then clamp.
   function automatic int model_cent(input int a, input int n);
      int q;
      q = a / n;
      if (q > 8191)  q = 8191;
      if (q < -8192) q = -8192;
      return q;
   endfunction

   // write monitor
   always @(negedge clk) begin
      if (rst_n && cb_wr_en) begin
         wr_cnt++;
         mon_a = int'(cb_wr_addr);
         if (mon_a >= DEPTH) chk("wr_addr_range", mon_a, DEPTH - 1);
         else begin
            got_wr[mon_a]  = 1'b1;
            got_mem[mon_a] = int'($signed(cb_wr_data));
            chk($sformatf("wr_allowed[%0d]", mon_a), exp_wr[mon_a], 1);
            if (exp_wr[mon_a])
               chk($sformatf("wr_data[%0d]", mon_a), got_mem[mon_a], exp_mem[mon_a]);
         end
      end
   end

   task automatic prep();
      int n, d;
      exp_cycles = 0; exp_writes = 0; exp_chg = 0; wr_cnt = 0;
      for (int a = 0; a < DEPTH; a++) begin
         n = cnt_tab[a / NCO];
         got_wr[a] = 1'b0;
         exp_wr[a] = (n != 0);
         if (n != 0) begin
            exp_mem[a] = model_cent(int'(acc_mem[a]), n);
            d = exp_mem[a] - int'(old_mem[a]);
            exp_chg += (d < 0) ? -d : d;
            exp_cycles += 27;
            exp_writes++;
         end else begin
            exp_cycles += 2;
         end
      end
      for (int kk = 0; kk < NCW; kk++) frames_cnt_flat[kk*CW +: CW] = CW'(cnt_tab[kk]);
   endtask

   task automatic run_pass(input string tag, input int extra_start_at);
      longint t0;
      int waited;
      prep();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      t0 = cyc;
      chk({tag, "_busy_after_start"}, busy, 1);
      waited = 0;
      while (!done && waited < 8000) begin
         start = (waited == extra_start_at);
         @(negedge clk);
         waited++;
      end
      start = 1'b0;
      if (!done) chk({tag, "_done_timeout"}, 0, 1);
      else begin
         chk({tag, "_pass_cycles"}, cyc - t0, exp_cycles);
         chk({tag, "_busy_at_done"}, busy, 0);
      end
      chk({tag, "_write_count"}, wr_cnt, exp_writes);
      for (int a = 0; a < DEPTH; a++)
         if (got_wr[a] != exp_wr[a]) chk($sformatf("%s_wr_flag[%0d]", tag, a), got_wr[a], exp_wr[a]);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
`ifdef VQ_CENTROID_CHANGE_SUM_EN
      chk({tag, "_change_sum"}, change_sum, exp_chg);
`else
      chk({tag, "_change_sum"}, change_sum, 0);
`endif
   endtask

   typedef struct {
      int cw; int coef; int acc; int cnt; int expv;
   } vec_t;

   initial begin
      vec_t vt [14];
      int waited;

      vt[0]  = '{2, 0, -10, 4, -2};
      vt[1]  = '{2, 1, 10, 4, 2};
      vt[2]  = '{2, 2, -3, 4, 0};
      vt[3]  = '{2, 3, 7, 4, 1};
      vt[4]  = '{2, 4, -7, 4, -1};
      vt[5]  = '{0, 0, 'h7FFFFF, 1, 8191};
      vt[6]  = '{0, 1, -8388608, 1, -8192};
      vt[7]  = '{0, 2, -8192, 1, -8192};
      vt[8]  = '{0, 3, 8191, 1, 8191};
      vt[9]  = '{0, 4, -8193, 1, -8192};
      vt[10] = '{5, 0, 'h7FFFFF, 511, 8191};
      vt[11] = '{5, 1, -8388608, 511, -8192};
      vt[12] = '{5, 2, 51100, 511, 100};
      vt[13] = '{5, 3, -1022, 511, -2};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_en", cb_wr_en, 0);
      chk("rst_acc_rd_addr", acc_rd_addr, 0);
      chk("rst_cb_wr_data", cb_wr_data, 0);
      chk("rst_cb_rd_addr", cb_rd_addr, 0);
      chk("rst_change_sum", change_sum, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // A: counts 1, acc[i]=i, stray start mid-pass
      for (int a = 0; a < DEPTH; a++) begin acc_mem[a] = AW'(a); old_mem[a] = DW'(a + 3); end
      for (int kk = 0; kk < NCW; kk++) cnt_tab[kk] = 1;
      run_pass("identity", 300);
      for (int a = 0; a < DEPTH; a += 23) chk($sformatf("identity_val[%0d]", a), got_mem[a], a);

      // B: table vectors, codeword 3 skipped
      for (int a = 0; a < DEPTH; a++) begin
         acc_mem[a] = AW'($urandom_range(0, 40000)) - AW'(20000);
         old_mem[a] = DW'($urandom);
      end
      for (int kk = 0; kk < NCW; kk++) cnt_tab[kk] = 1;
      cnt_tab[3] = 0;
      for (int i = 0; i < 14; i++) begin
         cnt_tab[vt[i].cw] = vt[i].cnt;
         acc_mem[vt[i].cw*NCO + vt[i].coef] = AW'(vt[i].acc);
      end
      run_pass("table", -1);
      chk("table_cycles_ref", exp_cycles, 5291);
      for (int i = 0; i < 14; i++)
         chk($sformatf("vec%0d", i), got_mem[vt[i].cw*NCO + vt[i].coef], vt[i].expv);

      // C: random counts (some zero) and random sums
      for (int a = 0; a < DEPTH; a++) begin
         acc_mem[a] = AW'($urandom);
         old_mem[a] = DW'($urandom);
      end
      for (int kk = 0; kk < NCW; kk++)
         cnt_tab[kk] = ($urandom_range(0, 3) == 0) ? 0 :
                       ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(9, 511);
      run_pass("random", -1);

      // D: old 5, new 2 everywhere
      for (int a = 0; a < DEPTH; a++) begin acc_mem[a] = AW'(2); old_mem[a] = DW'(5); end
      for (int kk = 0; kk < NCW; kk++) cnt_tab[kk] = 1;
      run_pass("chgsum", -1);
`ifdef VQ_CENTROID_CHANGE_SUM_EN
      chk("chgsum_624", change_sum, 624);
`endif

      // E: reset during DIV of entry 50
      prep();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      waited = 0;
      while (wr_cnt < 50 && waited < 3000) begin @(negedge clk); waited++; end
      chk("midrst_reach_entry50", wr_cnt, 50);
      repeat (6) @(negedge clk);   // RD_ADDR, RD_DATA, then inside DIV
      chk("midrst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_wr_en", cb_wr_en, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("midrst_no_more_writes", wr_cnt, 50);
      chk("midrst_busy_after", busy, 0);
      chk("midrst_acc_rd_addr", acc_rd_addr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
